// File: rtl/alu_seq_param_if.sv
// alu_seq_param_if: request/result bundle between the R-type controller and alu_seq_param.
// The controller side is the master; the ALU side is the slave.
interface alu_seq_param_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALU_OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] F;
    logic [WIDTH-1:0] F_HI;
    logic             ZF;
    logic             OF;
    logic             CF;
    logic             ERR;

    modport master (
        output start, ALU_OP, A, B,
        input  busy, done, F, F_HI, ZF, OF, CF, ERR
    );

    modport slave (
        input  start, ALU_OP, A, B,
        output busy, done, F, F_HI, ZF, OF, CF, ERR
    );
endinterface

// File: rtl/alu_seq_param.sv
// alu_seq_param: registered multifunction ALU with flags, issued by start and
// answered by a one-cycle done pulse. Single-cycle ops complete in one clock.
// Optional iterative MULU/DIVU unit (shift-add / restoring, one bit per cycle)
// is enabled by defining ALU_SEQ_MULDIV_EN; without it those opcodes are illegal,
// busy is 0 and F_HI is 0.
module alu_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_param_if.slave bus
);
    localparam int S = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    logic             w_accept;
    logic             w_single;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [S-1:0]     w_shamt;
    logic [WIDTH-1:0] w_f;
    logic             w_zf;
    logic             w_of;
    logic             w_cf;
    logic             w_err;

    logic [WIDTH-1:0] r_f;
    logic             r_zf;
    logic             r_of;
    logic             r_cf;
    logic             r_err;
    logic             r_done;

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [3:0] OP_MULU = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [S-1:0]     r_cnt;
    logic [WIDTH-1:0] r_acc_hi;   // product high half / partial remainder
    logic [WIDTH-1:0] r_acc_lo;   // multiplier being consumed / dividend becoming quotient
    logic [WIDTH-1:0] r_opd;      // multiplicand / divisor
    logic [WIDTH-1:0] r_fhi;
    logic [WIDTH-1:0] w_hi;
    logic             w_mul_go;
    logic             w_div_go;
    logic             w_iter_fin;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_rem_sub;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_it_hi;
    logic [WIDTH-1:0] w_it_lo;

    assign w_accept   = bus.start && (r_state == ST_IDLE);
    assign w_mul_go   = w_accept && (bus.ALU_OP == OP_MULU);
    // Divide by zero never iterates; it is answered as a single-cycle op.
    assign w_div_go   = w_accept && (bus.ALU_OP == OP_DIVU) && (bus.B != '0);
    assign w_single   = w_accept && !w_mul_go && !w_div_go;
    assign w_iter_fin = (r_state != ST_IDLE) && (r_cnt == '0);
    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.F_HI   = r_fhi;

    // One iteration step for whichever multi-cycle op is running.
    always_comb begin
        w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opd} : '0);
        w_rem_sh  = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_q_bit   = (w_rem_sh >= {1'b0, r_opd});
        // Remainder stays below the divisor, so the difference fits in WIDTH bits.
        w_rem_sub = w_rem_sh[WIDTH-1:0] - r_opd;
        if (r_state == ST_MUL) begin
            w_it_hi = w_mul_sum[WIDTH:1];
            w_it_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
        end else begin
            w_it_hi = w_q_bit ? w_rem_sub : w_rem_sh[WIDTH-1:0];
            w_it_lo = {r_acc_lo[WIDTH-2:0], w_q_bit};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nx;
    end

    // FSM next state: leave IDLE on an iterative op, return when the count expires.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mul_go)      w_state_nx = ST_MUL;
                else if (w_div_go) w_state_nx = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (r_cnt == '0) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Iteration datapath: load operands on accept, then step once per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opd    <= '0;
        end else if (w_mul_go) begin
            r_cnt    <= S'(WIDTH - 1);
            r_acc_hi <= '0;
            r_acc_lo <= bus.B;
            r_opd    <= bus.A;
        end else if (w_div_go) begin
            r_cnt    <= S'(WIDTH - 1);
            r_acc_hi <= '0;
            r_acc_lo <= bus.A;
            r_opd    <= bus.B;
        end else if (r_state != ST_IDLE) begin
            r_acc_hi <= w_it_hi;
            r_acc_lo <= w_it_lo;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
    end
`else
    assign w_accept = bus.start;
    assign w_single = w_accept;
    assign bus.busy = 1'b0;
    assign bus.F_HI = '0;
`endif

    assign w_sum   = {1'b0, bus.A} + {1'b0, bus.B};
    assign w_diff  = {1'b0, bus.A} - {1'b0, bus.B};
    assign w_shamt = bus.A[S-1:0];
    assign w_zf    = (w_f == '0);

    // Single-cycle result and flags; unknown opcodes give F=0 with ERR.
    always_comb begin
        w_f   = '0;
        w_of  = 1'b0;
        w_cf  = 1'b0;
        w_err = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
        w_hi  = '0;
`endif
        case (bus.ALU_OP)
            OP_AND:  w_f = bus.A & bus.B;
            OP_OR:   w_f = bus.A | bus.B;
            OP_XOR:  w_f = bus.A ^ bus.B;
            OP_NOR:  w_f = ~(bus.A | bus.B);
            OP_ADD: begin
                w_f  = w_sum[WIDTH-1:0];
                w_cf = w_sum[WIDTH];
                w_of = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                w_f  = w_diff[WIDTH-1:0];
                w_cf = w_diff[WIDTH];
                w_of = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SLTU: w_f = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OP_SLT:  w_f = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLL:  w_f = bus.B << w_shamt;
            OP_SRL:  w_f = bus.B >> w_shamt;
            OP_SRA:  w_f = $unsigned($signed(bus.B) >>> w_shamt);
`ifdef ALU_SEQ_MULDIV_EN
            OP_MULU: ;
            OP_DIVU: begin
                // Only reaches the result registers when B==0.
                w_f   = '1;
                w_hi  = bus.A;
                w_err = 1'b1;
            end
`endif
            default: w_err = 1'b1;
        endcase
    end

    // Result registers: written on single-cycle accept or iteration finish, else held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f    <= '0;
            r_zf   <= 1'b0;
            r_of   <= 1'b0;
            r_cf   <= 1'b0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            r_fhi  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_single) begin
                r_f    <= w_f;
                r_zf   <= w_zf;
                r_of   <= w_of;
                r_cf   <= w_cf;
                r_err  <= w_err;
                r_done <= 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
                r_fhi  <= w_hi;
            end else if (w_iter_fin) begin
                r_f    <= w_it_lo;
                r_fhi  <= w_it_hi;
                // A product is zero only if both halves are; a quotient looks at F alone.
                r_zf   <= (r_state == ST_MUL) ? ({w_it_hi, w_it_lo} == '0) : (w_it_lo == '0);
                r_of   <= 1'b0;
                r_cf   <= 1'b0;
                r_err  <= 1'b0;
                r_done <= 1'b1;
`endif
            end
        end
    end

    assign bus.done = r_done;
    assign bus.F    = r_f;
    assign bus.ZF   = r_zf;
    assign bus.OF   = r_of;
    assign bus.CF   = r_cf;
    assign bus.ERR  = r_err;
endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: directed vectors; expected results queued at issue time and
// compared by an independent monitor on every done pulse.
module tb_alu_seq_param;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_seq_param_if #(.WIDTH(W)) bus();

    alu_seq_param #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] f;
        logic [W-1:0] fhi;
        logic         zf;
        logic         of;
        logic         cf;
        logic         err;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    exp_t  mon_got;
    exp_t  mon_exp;
    string mon_nm;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, expv);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            mon_got = {bus.F, bus.F_HI, bus.ZF, bus.OF, bus.CF, bus.ERR};
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_nm  = name_q.pop_front();
                chk(mon_nm, mon_got, mon_exp);
            end
        end
    end

    task automatic issue(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] f, input logic [W-1:0] fhi,
                         input logic zf, input logic of, input logic cf, input logic err,
                         input bit push = 1'b1, input bit now = 1'b0);
        exp_t e;
        if (!now) @(negedge clk);
        bus.start  = 1'b1;
        bus.ALU_OP = op;
        bus.A      = a;
        bus.B      = b;
        if (push) begin
            e = {f, fhi, zf, of, cf, err};
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Follow an iterative op to its done pulse, poking ignored starts and
    // operand changes while busy. Returns at the negedge where done is seen.
    task automatic wait_iter(input string nm);
        int  cyc;
        bit  seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (cyc == 1) chk({nm, "_busy"}, bus.busy, 1'b1);
                bus.start  = (cyc >= 2 && cyc <= 4);
                bus.ALU_OP = 4'b0100;
                bus.A      = cyc;
                bus.B      = 32'h1234;
            end
        end
        bus.start = 1'b0;
        chk({nm, "_latency"}, cyc, W + 1);
        chk({nm, "_busy_low_at_done"}, bus.busy, 1'b0);
    endtask

    initial begin
        bit abort_done;
        bus.start  = 1'b0;
        bus.ALU_OP = 4'b0000;
        bus.A      = '0;
        bus.B      = '0;

        // Power-on reset state.
        repeat (2) @(negedge clk);
        chk("reset_state", {bus.busy, bus.done, bus.F, bus.F_HI, bus.ZF, bus.OF, bus.CF, bus.ERR}, '0);
        rst = 1'b0;

        // Make outputs non-zero, then reset asynchronously between edges.
        issue("sub_0_1", 4'b0101, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'h0, 0, 0, 1, 0);
        idle();
        #3 rst = 1'b1;
        #1 chk("async_reset", {bus.busy, bus.done, bus.F, bus.F_HI, bus.ZF, bus.OF, bus.CF, bus.ERR}, '0);
        @(negedge clk);
        rst = 1'b0;

        // First op after reset and single-cycle done timing.
        issue("add_1_2", 4'b0100, 32'd1, 32'd2, 32'd3, 32'h0, 0, 0, 0, 0);
        idle();
        chk("done_after_one_edge", bus.done, 1'b1);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 1'b0);

        // Back-to-back single-cycle ops.
        issue("add_ovf",   4'b0100, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0, 0, 1, 0, 0);
        issue("add_carry", 4'b0100, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1, 0, 1, 0);
        issue("sub_5_5",   4'b0101, 32'd5, 32'd5, 32'h0, 32'h0, 1, 0, 0, 0);
        issue("sub_ovf",   4'b0101, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 32'h0, 0, 1, 0, 0);
        issue("and",       4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0, 0, 0, 0, 0);
        issue("or",        4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 32'h0, 0, 0, 0, 0);
        issue("xor",       4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 0, 0, 0, 0);
        issue("nor",       4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 32'h0, 0, 0, 0, 0);
        issue("sltu",      4'b0110, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1, 0, 0, 0);
        issue("slt",       4'b1000, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 0, 0, 0, 0);
        issue("sra",       4'b1010, 32'd4, 32'h8000_0000, 32'hF800_0000, 32'h0, 0, 0, 0, 0);
        issue("srl",       4'b1001, 32'd4, 32'h8000_0000, 32'h0800_0000, 32'h0, 0, 0, 0, 0);
        issue("sll_33",    4'b0111, 32'd33, 32'h3, 32'h6, 32'h0, 0, 0, 0, 0);
        issue("illegal_f", 4'b1111, 32'h1234, 32'h5678, 32'h0, 32'h0, 1, 0, 0, 1);
        issue("illegal_d", 4'b1101, 32'hFFFF, 32'hFFFF, 32'h0, 32'h0, 1, 0, 0, 1);
        idle();

`ifdef ALU_SEQ_MULDIV_EN
        issue("mulu_max", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        wait_iter("mulu_max");
        // Accepted in the done cycle.
        issue("add_at_done", 4'b0100, 32'd10, 32'd20, 32'd30, 32'h0, 0, 0, 0, 0, 1'b1, 1'b1);
        idle();
        issue("mulu_hi_only", 4'b1011, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 0, 0, 0, 0);
        wait_iter("mulu_hi_only");
        issue("mulu_zero", 4'b1011, 32'h0, 32'd5, 32'h0, 32'h0, 1, 0, 0, 0, 1'b1, 1'b1);
        wait_iter("mulu_zero");
        issue("divu_100_7", 4'b1100, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0, 0, 1'b1, 1'b1);
        wait_iter("divu_100_7");
        issue("divu_3_7", 4'b1100, 32'd3, 32'd7, 32'd0, 32'd3, 1, 0, 0, 0, 1'b1, 1'b1);
        wait_iter("divu_3_7");
        issue("divu_by_0", 4'b1100, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0, 0, 0, 1, 1'b1, 1'b1);
        idle();
        chk("divu_by_0_no_busy", bus.busy, 1'b0);

        // Abort a division with reset: busy drops at once and no done follows.
        issue("div_abort", 4'b1100, 32'd1000, 32'd3, 32'h0, 32'h0, 0, 0, 0, 0, 1'b0);
        idle();
        repeat (5) @(negedge clk);
        chk("busy_mid_div", bus.busy, 1'b1);
        #2 rst = 1'b1;
        #1 chk("abort_busy_drop", {bus.busy, bus.done}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        abort_done = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.done === 1'b1) abort_done = 1'b1;
        end
        chk("abort_no_done", abort_done, 1'b0);
`else
        issue("mulu_illegal", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1, 0, 0, 1);
        idle();
        chk("mulu_no_busy", bus.busy, 1'b0);
        issue("divu_illegal", 4'b1100, 32'd100, 32'd7, 32'h0, 32'h0, 1, 0, 0, 1);
        idle();
        chk("divu_no_busy", bus.busy, 1'b0);
        chk("fhi_tied_zero", bus.F_HI, 32'h0);
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_seq_param.md
# alu_seq_param

Parametrised, registered successor to the 32-bit combinational multifunction ALU. It adds configurable width, signed compare, right shifts, carry and error flags, and an optional iterative multiply/divide unit behind a start/busy/done handshake. It sits between the register file read ports and the writeback mux of the R-type datapath. The controller issues one operation per `start` and captures `F` when `done` pulses.

## Interface
- `WIDTH`, default 32: operand and result width. Legal range is 4 to 64; power of two only.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Sampled only when `busy`=0.
- `ALU_OP`  in  4  operation code, latched on accept.
- `A`  in  WIDTH  operand A, latched on accept. Also supplies the shift amount.
- `B`  in  WIDTH  operand B, latched on accept. Also the value being shifted.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse: result outputs updated.
- `F`  out  WIDTH  result (low half of product, or quotient).
- `F_HI`  out  WIDTH  high half of product, or remainder. 0 for all other ops.
- `ZF`  out  1  F==0. For MULU, set only when {F_HI,F}==0.
- `OF`  out  1  signed overflow (ADD/SUB only, else 0).
- `CF`  out  1  carry-out for ADD, borrow for SUB, else 0.
- `ERR`  out  1  illegal opcode or divide by zero.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 NOR.
  - 0100 ADD, 0101 SUB.
  - 0110 SLTU: F = (A<B unsigned) ? 1 : 0.
  - 0111 SLL: F = B << A[S-1:0], where S = log2(WIDTH).
  - 1000 SLT: same as SLTU but signed compare.
  - 1001 SRL: B >> A[S-1:0]. 1010 SRA: arithmetic shift of B by A[S-1:0].
  - 1011 MULU, 1100 DIVU: multi-cycle, macro-gated.
  - 1101–1111: illegal.
- Arithmetic is computed at WIDTH+1 bits.
  - CF = bit WIDTH of the sum, or of A−B (borrow).
  - OF for ADD: A[W-1]==B[W-1] and F[W-1]!=A[W-1].
  - OF for SUB: A[W-1]!=B[W-1] and F[W-1]!=A[W-1].
  - OF and CF are never X.
- States: IDLE, MUL, DIV. `busy` = (state != IDLE).
- IDLE, start=1, single-cycle op: register all results, pulse `done`, remain in IDLE.
- IDLE, start=1, MULU: latch operands, clear accumulator, go to MUL, load counter with WIDTH-1.
  - MUL performs unsigned shift-add, one bit per cycle.
  - When count reaches 0, write {F_HI,F}, pulse `done`, return to IDLE.
- IDLE, start=1, DIVU with B≠0: go to DIV.
  - DIV performs restoring division, one quotient bit per cycle, same counter.
  - On exit, F = quotient and F_HI = remainder.
- DIVU with B==0: no iteration. Single-cycle result: F = all ones, F_HI = A, ERR=1.
- Illegal opcode: single-cycle result: F=0, F_HI=0, ZF=1, OF=CF=0, ERR=1.
- `start` while `busy`=1 is ignored; operand changes while busy have no effect.
- Result outputs hold their value between `done` pulses. ERR is updated on every `done`.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, counter=0.
  - busy=0, done=0, F=0, F_HI=0, ZF=0, OF=0, CF=0, ERR=0.
- Reset asserted mid-MUL/DIV aborts the operation. No `done` is issued.
- Single-cycle ops: start sampled at edge k; results valid and `done`=1 after edge k.
  - Back-to-back issue every cycle is supported.
- MULU/DIVU: start sampled at edge k.
  - `busy`=1 after edges k .. k+WIDTH-1.
  - Results, `done`=1 and `busy`=0 after edge k+WIDTH (latency WIDTH cycles).
- A `start` in the same cycle as `done` is accepted, because state is IDLE that cycle.
- `done` is high for exactly one cycle per accepted op.

## Configuration
- Macro: `ALU_SEQ_MULDIV_EN`.
- Defined: MULU/DIVU as described, and MUL/DIV states exist.
- Undefined:
  - 1011 and 1100 are treated as illegal: single-cycle, ERR=1.
  - No MUL/DIV states and no iteration counter.
  - `busy` is tied to 0 and `F_HI` is tied to 0.

## Test plan
- Reset: assert rst mid-cycle → all outputs 0 asynchronously. Then issue ADD 1+2 → F=3, done pulse one cycle after start.
- ADD 0x7FFFFFFF+1 → F=0x80000000, OF=1, CF=0. SUB 0−1 → F=0xFFFFFFFF, CF=1, OF=0. SUB 5−5 → ZF=1.
- SLTU vs SLT with A=0xFFFFFFFF, B=1 → SLTU gives F=0, SLT gives F=1. SRA with A=4, B=0x80000000 → F=0xF8000000. SLL with A=33 → shift by 1.
- MULU 0xFFFFFFFF × 0xFFFFFFFF (macro on):
  - busy for 32 cycles; start pulses during busy are ignored.
  - Then F=0x00000001, F_HI=0xFFFFFFFE, done high one cycle.
- DIVU 100/7 → F=14, F_HI=2 after 32 cycles. DIVU 5/0 → single-cycle, ERR=1, F=0xFFFFFFFF, F_HI=5.
- Illegal opcode 1111 → ERR=1, F=0, ZF=1. Reset mid-DIV → busy drops immediately, no done. Macro off: MULU gives ERR=1 and busy stays 0.
